// File: rtl/npu_acc_fifo_if.sv
// Accumulator FIFO bus: push from the last PE, pop/offset read toward the first PE,
// plus occupancy and sticky error status.
interface npu_acc_fifo_if #(
  parameter int ADDR_W = 4
);
  logic              npu_acc_wr_en;
  logic [47:0]       npu_acc_wr_data;
  logic              npu_acc_rd_en;
  logic              npu_acc_first_pass;
  logic [47:0]       npu_acc_offset_in;
  logic              npu_acc_err_clr;
  logic [47:0]       npu_acc_out;
  logic              npu_acc_out_vld;
  logic              npu_acc_full;
  logic              npu_acc_empty;
  logic [ADDR_W:0]   npu_acc_count;
  logic              npu_acc_ovf;
  logic              npu_acc_unf;

  modport master (
    output npu_acc_wr_en, npu_acc_wr_data, npu_acc_rd_en, npu_acc_first_pass,
           npu_acc_offset_in, npu_acc_err_clr,
    input  npu_acc_out, npu_acc_out_vld, npu_acc_full, npu_acc_empty,
           npu_acc_count, npu_acc_ovf, npu_acc_unf
  );

  modport slave (
    input  npu_acc_wr_en, npu_acc_wr_data, npu_acc_rd_en, npu_acc_first_pass,
           npu_acc_offset_in, npu_acc_err_clr,
    output npu_acc_out, npu_acc_out_vld, npu_acc_full, npu_acc_empty,
           npu_acc_count, npu_acc_ovf, npu_acc_unf
  );
endinterface

// File: rtl/npu_acc_fifo.sv
// Partial-sum FIFO between the last and first PE of the chain, with a bias-offset
// bypass for the first pass and sticky overflow/underflow flags.
module npu_acc_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic           CLK,
  input  logic           npu_rst,
  npu_acc_fifo_if.slave  bus
);

  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [47:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   count_nxt;

  logic pop_ok;
  logic push_ok;
  logic offset_rd;
  logic ovf_evt;
  logic unf_evt;

  // Pop never falls through an empty FIFO; a full FIFO still takes a push if it pops.
  always_comb begin
    pop_ok    = bus.npu_acc_rd_en & ~bus.npu_acc_first_pass & ~bus.npu_acc_empty;
    push_ok   = bus.npu_acc_wr_en & (~bus.npu_acc_full | pop_ok);
    offset_rd = bus.npu_acc_rd_en & bus.npu_acc_first_pass;
    ovf_evt   = bus.npu_acc_wr_en & bus.npu_acc_full & ~pop_ok;
    unf_evt   = bus.npu_acc_rd_en & ~bus.npu_acc_first_pass & bus.npu_acc_empty;
    count_nxt = count;
    if (push_ok && !pop_ok) begin
      count_nxt = count + CNT_ONE;
    end else if (pop_ok && !push_ok) begin
      count_nxt = count - CNT_ONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem[wr_ptr] <= bus.npu_acc_wr_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (npu_rst) begin
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      count               <= '0;
      bus.npu_acc_full    <= 1'b0;
      bus.npu_acc_empty   <= 1'b1;
      bus.npu_acc_out     <= '0;
      bus.npu_acc_out_vld <= 1'b0;
      bus.npu_acc_ovf     <= 1'b0;
      bus.npu_acc_unf     <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count             <= count_nxt;
      bus.npu_acc_full  <= (count_nxt == DEPTH_C);
      bus.npu_acc_empty <= (count_nxt == '0);

      if (pop_ok) begin
        bus.npu_acc_out     <= mem[rd_ptr];
        bus.npu_acc_out_vld <= 1'b1;
      end else if (offset_rd) begin
        bus.npu_acc_out     <= bus.npu_acc_offset_in;
        bus.npu_acc_out_vld <= 1'b1;
      end else begin
        bus.npu_acc_out_vld <= 1'b0;
      end

      // A new error in the clearing cycle wins over the clear.
      bus.npu_acc_ovf <= ovf_evt | (bus.npu_acc_ovf & ~bus.npu_acc_err_clr);
      bus.npu_acc_unf <= unf_evt | (bus.npu_acc_unf & ~bus.npu_acc_err_clr);
    end
  end

  assign bus.npu_acc_count = count;

endmodule
